// File: rtl/directory_controller.sv
// Two-cache directory: per-block state, sharer vector and backing memory, with an
// IDLE/LOOKUP/NOTIFY/REMOTE/REPLY transaction FSM and round-robin request arbitration.
module directory_controller #(
    parameter int WB_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [2:0] interconnectionMessageC0ToL1,
    input  logic [2:0] interconnectionMessageC1ToL1,
    input  logic [7:0] addressToL1C0,
    input  logic [7:0] addressToL1C1,
    input  logic       dataWriteBackC0,
    input  logic       dataWriteBackC1,
    input  logic [7:0] dataBypassC0,
    input  logic [7:0] dataBypassC1,
    output logic [2:0] interconnectionMessageC0FromL1,
    output logic [2:0] interconnectionMessageC1FromL1,
    output logic [7:0] addressFromL1,
    output logic [7:0] fetchDataC0,
    output logic [7:0] fetchDataC1,
    output logic [7:0] fetchAddressC0,
    output logic [7:0] fetchAddressC1,
    output logic       fetchPresentC0,
    output logic       fetchPresentC1,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOOKUP, NOTIFY, REMOTE, REPLY} stateT;

    localparam logic [1:0] UNCACHED  = 2'b00;
    localparam logic [1:0] SHARED    = 2'b01;
    localparam logic [1:0] EXCLUSIVE = 2'b10;

    stateT state, nextState;

    logic [1:0] dirState [256];
    logic [1:0] sharers  [256];
    logic [7:0] mem      [256];

    logic       reqId, reqRd, reqWr;
    logic [7:0] reqAddr;
    logic [2:0] notifyMsg;
    logic       waitRemote;
    logic [1:0] finState, finSharers;
    logic [7:0] cnt;
    logic       lastGrant;
    logic       pendWb;
    logic [7:0] pendAddr, pendData;

    logic       wbDo, wbId;
    logic [7:0] wbAddr, wbData;
    logic       reqC0, reqC1, grantC1, startReq;
    logic [2:0] selMsg;
    logic [7:0] selAddr;
    logic [1:0] curSt, curSh, reqBit;
    logic       otherHeld, ownedByOther;
    logic [2:0] lkMsg;
    logic       lkWait;
    logic [1:0] lkSt, lkSh, updSt, updSh;
    logic       ownerWb;
    logic [7:0] ownerData;
    logic       enterReply;

    // Unsolicited write-backs in IDLE; a deferred C1 strobe goes first on the following cycle
    always_comb begin
        wbDo   = 1'b0;
        wbId   = 1'b0;
        wbAddr = 8'h00;
        wbData = 8'h00;
        if (state == IDLE) begin
            if (pendWb) begin
                wbDo = 1'b1; wbId = 1'b1; wbAddr = pendAddr; wbData = pendData;
            end else if (dataWriteBackC0) begin
                wbDo = 1'b1; wbId = 1'b0; wbAddr = addressToL1C0; wbData = dataBypassC0;
            end else if (dataWriteBackC1) begin
                wbDo = 1'b1; wbId = 1'b1; wbAddr = addressToL1C1; wbData = dataBypassC1;
            end
        end
    end

    assign reqC0    = |interconnectionMessageC0ToL1;
    assign reqC1    = |interconnectionMessageC1ToL1;
    assign grantC1  = reqC1 && (!reqC0 || lastGrant);
    assign startReq = (state == IDLE) && !wbDo && (reqC0 || reqC1);
    assign selMsg   = grantC1 ? interconnectionMessageC1ToL1 : interconnectionMessageC0ToL1;
    assign selAddr  = grantC1 ? addressToL1C1 : addressToL1C0;

    // Coherence decision made during LOOKUP from the current directory entry
    always_comb begin
        curSt        = dirState[reqAddr];
        curSh        = sharers[reqAddr];
        reqBit       = reqId ? 2'b10 : 2'b01;
        otherHeld    = reqId ? curSh[0] : curSh[1];
        ownedByOther = (curSt == EXCLUSIVE) && otherHeld;
        lkMsg        = 3'b000;
        lkWait       = 1'b0;
        lkSt         = EXCLUSIVE;
        lkSh         = reqBit;
        if (reqRd) begin
            lkSt = SHARED;
            if (ownedByOther) begin
                lkMsg = 3'b100; lkWait = 1'b1; lkSh = 2'b11;
            end else begin
                lkSh = curSh | reqBit;
            end
        end else if (reqWr && ownedByOther) begin
            lkMsg = 3'b010; lkWait = 1'b1;
        end else if (otherHeld) begin
            lkMsg = 3'b001;
        end
    end

    assign ownerWb    = (state == REMOTE) && (reqId ? dataWriteBackC0 : dataWriteBackC1);
    assign ownerData  = reqId ? dataBypassC0 : dataBypassC1;
    assign enterReply = (nextState == REPLY) && (state != REPLY);
    assign updSt      = (state == LOOKUP) ? lkSt : finState;
    assign updSh      = (state == LOOKUP) ? lkSh : finSharers;

    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startReq) nextState = LOOKUP;
            LOOKUP:  nextState = (lkMsg != 3'b000) ? NOTIFY : REPLY;
            NOTIFY:  nextState = waitRemote ? REMOTE : REPLY;
            REMOTE:  if (ownerWb || cnt == 8'(WB_TIMEOUT)) nextState = REPLY;
            REPLY:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        interconnectionMessageC0FromL1 = 3'b000;
        interconnectionMessageC1FromL1 = 3'b000;
        addressFromL1  = 8'h00;
        fetchDataC0    = 8'h00;
        fetchDataC1    = 8'h00;
        fetchAddressC0 = 8'h00;
        fetchAddressC1 = 8'h00;
        fetchPresentC0 = 1'b0;
        fetchPresentC1 = 1'b0;
        busy           = (state != IDLE);
        case (state)
            NOTIFY: begin
                addressFromL1 = reqAddr;
                if (reqId) interconnectionMessageC0FromL1 = notifyMsg;
                else       interconnectionMessageC1FromL1 = notifyMsg;
            end
            REPLY: begin
                if (reqId) begin
                    fetchPresentC1 = 1'b1; fetchDataC1 = mem[reqAddr]; fetchAddressC1 = reqAddr;
                end else begin
                    fetchPresentC0 = 1'b1; fetchDataC0 = mem[reqAddr]; fetchAddressC0 = reqAddr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < 256; i++) begin
                dirState[i] <= UNCACHED;
                sharers[i]  <= 2'b00;
                mem[i]      <= 8'h00;
            end
            reqId      <= 1'b0;
            reqRd      <= 1'b0;
            reqWr      <= 1'b0;
            reqAddr    <= 8'h00;
            notifyMsg  <= 3'b000;
            waitRemote <= 1'b0;
            finState   <= UNCACHED;
            finSharers <= 2'b00;
            cnt        <= 8'h00;
            lastGrant  <= 1'b0;
            pendWb     <= 1'b0;
            pendAddr   <= 8'h00;
            pendData   <= 8'h00;
        end else begin
            pendWb <= (state == IDLE) && !pendWb && dataWriteBackC0 && dataWriteBackC1;
            if (!pendWb) begin
                pendAddr <= addressToL1C1;
                pendData <= dataBypassC1;
            end
            if (wbDo) begin
                mem[wbAddr] <= wbData;
                if (dirState[wbAddr] == EXCLUSIVE && sharers[wbAddr][wbId]) begin
                    dirState[wbAddr] <= UNCACHED;
                    sharers[wbAddr]  <= 2'b00;
                end else begin
                    sharers[wbAddr][wbId] <= 1'b0;
                end
            end
            if (startReq) begin
                reqId     <= grantC1;
                reqRd     <= selMsg[2];
                reqWr     <= !selMsg[2] && selMsg[1];
                reqAddr   <= selAddr;
                lastGrant <= !lastGrant;
            end
            if (state == LOOKUP) begin
                notifyMsg  <= lkMsg;
                waitRemote <= lkWait;
                finState   <= lkSt;
                finSharers <= lkSh;
            end
            if (state == NOTIFY)      cnt <= 8'd1;
            else if (state == REMOTE) cnt <= cnt + 8'd1;
            if (ownerWb) mem[reqAddr] <= ownerData;
            if (enterReply) begin
                dirState[reqAddr] <= updSt;
                sharers[reqAddr]  <= updSh;
            end
        end
    end
endmodule

// File: tb/tb_directory_controller.sv
// Bench for directory_controller: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a rule-level directory model.
module tb_directory_controller;
    localparam int WBT = 15;

    logic       clk = 1'b0;
    logic       resetN;
    logic [2:0] interconnectionMessageC0ToL1, interconnectionMessageC1ToL1;
    logic [7:0] addressToL1C0, addressToL1C1;
    logic       dataWriteBackC0, dataWriteBackC1;
    logic [7:0] dataBypassC0, dataBypassC1;
    logic [2:0] interconnectionMessageC0FromL1, interconnectionMessageC1FromL1;
    logic [7:0] addressFromL1;
    logic [7:0] fetchDataC0, fetchDataC1, fetchAddressC0, fetchAddressC1;
    logic       fetchPresentC0, fetchPresentC1, busy;

    always #5 clk = ~clk;

    directory_controller #(.WB_TIMEOUT(WBT)) dut (
        .clk(clk), .resetN(resetN),
        .interconnectionMessageC0ToL1(interconnectionMessageC0ToL1),
        .interconnectionMessageC1ToL1(interconnectionMessageC1ToL1),
        .addressToL1C0(addressToL1C0), .addressToL1C1(addressToL1C1),
        .dataWriteBackC0(dataWriteBackC0), .dataWriteBackC1(dataWriteBackC1),
        .dataBypassC0(dataBypassC0), .dataBypassC1(dataBypassC1),
        .interconnectionMessageC0FromL1(interconnectionMessageC0FromL1),
        .interconnectionMessageC1FromL1(interconnectionMessageC1FromL1),
        .addressFromL1(addressFromL1),
        .fetchDataC0(fetchDataC0), .fetchDataC1(fetchDataC1),
        .fetchAddressC0(fetchAddressC0), .fetchAddressC1(fetchAddressC1),
        .fetchPresentC0(fetchPresentC0), .fetchPresentC1(fetchPresentC1),
        .busy(busy)
    );

    typedef struct {
        bit         c;
        logic [2:0] msg;
        logic [7:0] addr;
        int         d;
        logic [7:0] wbd;
        int         lat;
        logic [7:0] data;
        logic [2:0] n0;
        logic [2:0] n1;
        logic [1:0] st;
        logic [1:0] sh;
    } vec_t;

    int nVec = 0;
    int nFail = 0;

    logic [1:0] mSt  [256];
    logic [1:0] mSh  [256];
    logic [7:0] mMem [256];

    task automatic chk(input string nm, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(bit c, logic [2:0] msg, logic [7:0] addr, int d, logic [7:0] wbd,
                                int lat, logic [7:0] data, logic [2:0] n0, logic [2:0] n1,
                                logic [1:0] st, logic [1:0] sh);
        vec_t v;
        v.c = c; v.msg = msg; v.addr = addr; v.d = d; v.wbd = wbd; v.lat = lat;
        v.data = data; v.n0 = n0; v.n1 = n1; v.st = st; v.sh = sh;
        return v;
    endfunction

    function automatic int allOutputs();
        return int'(|{interconnectionMessageC0FromL1, interconnectionMessageC1FromL1, addressFromL1,
                      fetchDataC0, fetchDataC1, fetchAddressC0, fetchAddressC1,
                      fetchPresentC0, fetchPresentC1, busy});
    endfunction

    task automatic clearInputs();
        interconnectionMessageC0ToL1 = 3'b000; interconnectionMessageC1ToL1 = 3'b000;
        addressToL1C0 = 8'h00; addressToL1C1 = 8'h00;
        dataWriteBackC0 = 1'b0; dataWriteBackC1 = 1'b0;
        dataBypassC0 = 8'h00; dataBypassC1 = 8'h00;
    endtask

    task automatic doReset();
        @(negedge clk);
        resetN = 1'b0;
        clearInputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mSt[i] = 2'b00; mSh[i] = 2'b00; mMem[i] = 8'h00;
        end
    endtask

    // Drives one request, answers owner notifications with a write-back after d cycles
    // (none if d >= WBT), and observes latency, reply and bus traffic.
    task automatic runReq(input bit c, input logic [2:0] msg, input logic [7:0] a, input int d,
                          input logic [7:0] wbd, output int lat, output int data, output int fa,
                          output int n0, output int n1, output int glitch);
        int wbAt;
        bit wbOn;
        bit wbOwnC1;
        int nCount;
        lat = -1; data = -1; fa = -1; n0 = 0; n1 = 0; glitch = 0;
        wbAt = -1; wbOn = 1'b0; wbOwnC1 = 1'b0; nCount = 0;
        @(negedge clk);
        if (c) begin interconnectionMessageC1ToL1 = msg; addressToL1C1 = a; end
        else   begin interconnectionMessageC0ToL1 = msg; addressToL1C0 = a; end
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clk);
            if (wbOn) begin dataWriteBackC0 = 1'b0; dataWriteBackC1 = 1'b0; wbOn = 1'b0; end
            if (interconnectionMessageC0FromL1 != 0 || interconnectionMessageC1FromL1 != 0) begin
                nCount++;
                if (addressFromL1 != a) glitch++;
                if (interconnectionMessageC0FromL1 != 0) n0 = int'(interconnectionMessageC0FromL1);
                if (interconnectionMessageC1FromL1 != 0) n1 = int'(interconnectionMessageC1FromL1);
                wbOwnC1 = (interconnectionMessageC1FromL1 != 0);
                if ((interconnectionMessageC0FromL1 | interconnectionMessageC1FromL1) != 3'b001 && d < WBT)
                    wbAt = n + 1 + d;
            end else if (addressFromL1 != 0) begin
                glitch++;
            end
            if (c ? fetchPresentC0 : fetchPresentC1) glitch++;
            if (c ? fetchPresentC1 : fetchPresentC0) begin
                lat  = n;
                data = int'(c ? fetchDataC1 : fetchDataC0);
                fa   = int'(c ? fetchAddressC1 : fetchAddressC0);
                if (c) interconnectionMessageC1ToL1 = 3'b000;
                else   interconnectionMessageC0ToL1 = 3'b000;
            end else if (n == wbAt) begin
                if (wbOwnC1) begin addressToL1C1 = a; dataBypassC1 = wbd; dataWriteBackC1 = 1'b1; end
                else         begin addressToL1C0 = a; dataBypassC0 = wbd; dataWriteBackC0 = 1'b1; end
                wbOn = 1'b1;
            end
        end
        if (nCount > 1) glitch++;
        if (lat < 0) begin
            interconnectionMessageC0ToL1 = 3'b000; interconnectionMessageC1ToL1 = 3'b000;
            dataWriteBackC0 = 1'b0; dataWriteBackC1 = 1'b0;
        end
    endtask

    // Directory rules: who must be told, how long the requester waits, what it gets back
    task automatic model(input bit c, input logic [2:0] msg, input logic [7:0] a, input int d,
                         input logic [7:0] wbd, output int lat, output int data,
                         output int n0, output int n1);
        bit o;
        bit otherHas;
        logic [1:0] me;
        int note;
        o = !c;
        me = c ? 2'b10 : 2'b01;
        otherHas = mSh[a][o];
        note = 0;
        lat = 2;
        if (msg[2]) begin
            if (mSt[a] == 2'b10 && otherHas) begin
                note = 4;
                if (d < WBT) begin mMem[a] = wbd; lat = 4 + d; end
                else lat = 3 + WBT;
                mSh[a] = 2'b11;
            end else begin
                mSh[a] = mSh[a] | me;
            end
            mSt[a] = 2'b01;
        end else begin
            if (msg[1] && mSt[a] == 2'b10 && otherHas) begin
                note = 2;
                if (d < WBT) begin mMem[a] = wbd; lat = 4 + d; end
                else lat = 3 + WBT;
            end else if (otherHas) begin
                note = 1;
                lat = 3;
            end
            mSt[a] = 2'b10;
            mSh[a] = me;
        end
        n0 = o ? 0 : note;
        n1 = o ? note : 0;
        data = int'(mMem[a]);
    endtask

    task automatic doReq(input bit c, input logic [2:0] msg, input logic [7:0] a, input int d,
                         input logic [7:0] wbd);
        int eLat, eData, eN0, eN1;
        int lat, data, fa, n0, n1, glitch;
        model(c, msg, a, d, wbd, eLat, eData, eN0, eN1);
        runReq(c, msg, a, d, wbd, lat, data, fa, n0, n1, glitch);
        chk("rnd latency", lat, eLat);
        chk("rnd fetchData", data, eData);
        chk("rnd fetchAddress", fa, int'(a));
        chk("rnd notifyC0", n0, eN0);
        chk("rnd notifyC1", n1, eN1);
        chk("rnd bus glitches", glitch, 0);
        chk("rnd dirState", int'(dut.dirState[a]), int'(mSt[a]));
        chk("rnd sharers", int'(dut.sharers[a]), int'(mSh[a]));
    endtask

    task automatic unsolWb(input bit c, input logic [7:0] a, input logic [7:0] wd);
        @(negedge clk);
        if (c) begin addressToL1C1 = a; dataBypassC1 = wd; dataWriteBackC1 = 1'b1; end
        else   begin addressToL1C0 = a; dataBypassC0 = wd; dataWriteBackC0 = 1'b1; end
        @(negedge clk);
        dataWriteBackC0 = 1'b0; dataWriteBackC1 = 1'b0;
        mMem[a] = wd;
        if (mSt[a] == 2'b10 && mSh[a][c]) begin mSt[a] = 2'b00; mSh[a] = 2'b00; end
        else mSh[a][c] = 1'b0;
        chk("wb busy", int'(busy), 0);
        chk("wb mem", int'(dut.mem[a]), int'(mMem[a]));
        chk("wb dirState", int'(dut.dirState[a]), int'(mSt[a]));
        chk("wb sharers", int'(dut.sharers[a]), int'(mSh[a]));
    endtask

    initial begin
        vec_t tbl[12];
        int lat, data, fa, n0, n1, glitch;
        int ord[3];
        int k, firstLat, secondAddr, presents;

        tbl[0]  = mk(0, 3'b100, 8'h12, 99, 8'h00, 2,  8'h00, 3'b000, 3'b000, 2'b01, 2'b01);
        tbl[1]  = mk(1, 3'b010, 8'h12, 99, 8'h00, 3,  8'h00, 3'b001, 3'b000, 2'b10, 2'b10);
        tbl[2]  = mk(0, 3'b100, 8'h12, 1,  8'h5A, 5,  8'h5A, 3'b000, 3'b100, 2'b01, 2'b11);
        tbl[3]  = mk(1, 3'b010, 8'h12, 99, 8'h00, 3,  8'h5A, 3'b001, 3'b000, 2'b10, 2'b10);
        tbl[4]  = mk(0, 3'b100, 8'h12, 99, 8'h77, 18, 8'h5A, 3'b000, 3'b100, 2'b01, 2'b11);
        tbl[5]  = mk(0, 3'b010, 8'h12, 99, 8'h00, 3,  8'h5A, 3'b000, 3'b001, 2'b10, 2'b01);
        tbl[6]  = mk(1, 3'b010, 8'h12, 0,  8'hC3, 4,  8'hC3, 3'b010, 3'b000, 2'b10, 2'b10);
        tbl[7]  = mk(1, 3'b001, 8'h12, 99, 8'h00, 2,  8'hC3, 3'b000, 3'b000, 2'b10, 2'b10);
        tbl[8]  = mk(0, 3'b111, 8'h20, 99, 8'h00, 2,  8'h00, 3'b000, 3'b000, 2'b01, 2'b01);
        tbl[9]  = mk(1, 3'b011, 8'h20, 99, 8'h00, 3,  8'h00, 3'b001, 3'b000, 2'b10, 2'b10);
        tbl[10] = mk(1, 3'b100, 8'h20, 99, 8'h00, 2,  8'h00, 3'b000, 3'b000, 2'b01, 2'b10);
        tbl[11] = mk(0, 3'b001, 8'h21, 99, 8'h00, 2,  8'h00, 3'b000, 3'b000, 2'b10, 2'b01);

        resetN = 1'b0;
        clearInputs();
        doReset();
        chk("reset outputs", allOutputs(), 0);
        chk("reset dirState", int'(dut.dirState[8'h12]), 0);
        chk("reset mem", int'(dut.mem[8'h12]), 0);

        for (int i = 0; i < 12; i++) begin
            runReq(tbl[i].c, tbl[i].msg, tbl[i].addr, tbl[i].d, tbl[i].wbd, lat, data, fa, n0, n1, glitch);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d fetchData", i), data, int'(tbl[i].data));
            chk($sformatf("vec%0d fetchAddress", i), fa, int'(tbl[i].addr));
            chk($sformatf("vec%0d notifyC0", i), n0, int'(tbl[i].n0));
            chk($sformatf("vec%0d notifyC1", i), n1, int'(tbl[i].n1));
            chk($sformatf("vec%0d bus glitches", i), glitch, 0);
            chk($sformatf("vec%0d dirState", i), int'(dut.dirState[tbl[i].addr]), int'(tbl[i].st));
            chk($sformatf("vec%0d sharers", i), int'(dut.sharers[tbl[i].addr]), int'(tbl[i].sh));
        end

        // Two ties in a row: C0 wins the first, C1 the second (C0 re-requests as soon as it is served)
        doReset();
        ord = '{-1, -1, -1};
        k = 0; firstLat = -1; secondAddr = -1;
        @(negedge clk);
        interconnectionMessageC0ToL1 = 3'b100; addressToL1C0 = 8'h30;
        interconnectionMessageC1ToL1 = 3'b100; addressToL1C1 = 8'h31;
        for (int n = 1; n <= 40 && k < 3; n++) begin
            @(negedge clk);
            if (fetchPresentC0) begin
                ord[k] = 0; k++;
                if (firstLat < 0) begin
                    firstLat = n;
                    addressToL1C0 = 8'h32;
                end else begin
                    secondAddr = int'(fetchAddressC0);
                    interconnectionMessageC0ToL1 = 3'b000;
                end
            end else if (fetchPresentC1) begin
                ord[k] = 1; k++;
                interconnectionMessageC1ToL1 = 3'b000;
            end
        end
        clearInputs();
        chk("tie first latency", firstLat, 2);
        chk("tie order 0", ord[0], 0);
        chk("tie order 1", ord[1], 1);
        chk("tie order 2", ord[2], 0);
        chk("tie C0 second address", secondAddr, 8'h32);

        // Reset asserted while waiting in REMOTE
        doReset();
        doReq(0, 3'b010, 8'h40, 99, 8'h00);
        @(negedge clk);
        interconnectionMessageC1ToL1 = 3'b100; addressToL1C1 = 8'h40;
        repeat (3) @(negedge clk);
        chk("remote busy", int'(busy), 1);
        resetN = 1'b0;
        @(negedge clk);
        chk("reset-in-remote busy", int'(busy), 0);
        chk("reset-in-remote outputs", allOutputs(), 0);
        clearInputs();
        resetN = 1'b1;
        presents = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (fetchPresentC0 || fetchPresentC1) presents++;
        end
        chk("reset-in-remote presents", presents, 0);
        chk("reset-in-remote dirState", int'(dut.dirState[8'h40]), 0);
        for (int i = 0; i < 256; i++) begin
            mSt[i] = 2'b00; mSh[i] = 2'b00; mMem[i] = 8'h00;
        end

        // Simultaneous write-backs: C0 (Exclusive owner of 3) first, C1 (non-holder of 4) a cycle later
        doReq(0, 3'b010, 8'h03, 99, 8'h00);
        @(negedge clk);
        addressToL1C0 = 8'h03; dataBypassC0 = 8'h11; dataWriteBackC0 = 1'b1;
        addressToL1C1 = 8'h04; dataBypassC1 = 8'h22; dataWriteBackC1 = 1'b1;
        @(negedge clk);
        dataWriteBackC0 = 1'b0; dataWriteBackC1 = 1'b0;
        @(negedge clk);
        mMem[3] = 8'h11; mSt[3] = 2'b00; mSh[3] = 2'b00;
        mMem[4] = 8'h22;
        chk("dual wb mem C0", int'(dut.mem[8'h03]), 8'h11);
        chk("dual wb mem C1", int'(dut.mem[8'h04]), 8'h22);
        chk("dual wb dirState", int'(dut.dirState[8'h03]), 0);
        doReq(1, 3'b100, 8'h04, 99, 8'h00);

        for (int i = 0; i < 120; i++) begin
            bit c;
            logic [7:0] a;
            c = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                unsolWb(c, a, 8'($urandom));
            else
                doReq(c, 3'($urandom_range(1, 7)), a, int'($urandom_range(0, 17)), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule

// File: doc/directory_controller.md
DIRECTORY_CONTROLLER -- requirements
Module: directory_controller

Interface
REQ-001 SHALL have parameter: WB_TIMEOUT, 15, maximum cycles REMOTE waits for an owner write-back (range 1..255).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: resetN  in  1  reset; synchronous, active-low, single clock domain.
REQ-004 SHALL have ports: interconnectionMessageC0ToL1 / interconnectionMessageC1ToL1  in  3 each  {readMiss, writeMiss, invalidate} from cache Cx; 000 means no request.
REQ-005 SHALL have ports: addressToL1C0 / addressToL1C1  in  8 each  block address of Cx's request or write-back.
REQ-006 SHALL have ports: dataWriteBackC0 / dataWriteBackC1  in  1 each  Cx write-back strobe.
REQ-007 SHALL have ports: dataBypassC0 / dataBypassC1  in  8 each  Cx write-back data.
REQ-008 SHALL have ports: interconnectionMessageC0FromL1 / interconnectionMessageC1FromL1  out  3 each  directory-to-Cx bus message.
REQ-009 SHALL have port: addressFromL1  out  8  address accompanying any FromL1 message.
REQ-010 SHALL have ports: fetchDataC0/C1  out  8; fetchAddressC0/C1  out  8; fetchPresentC0/C1  out  1  reply to Cx.
REQ-011 SHALL have port: busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL hold per-address (256 entries): dirState 2 bits (00 Uncached, 01 Shared, 10 Exclusive), sharers[1:0] (bit x = Cx), memory data 8 bits.
REQ-013 SHALL treat requests as level-held: Cx keeps its message and address stable until its fetchPresentCx pulse.
REQ-014 SHALL, for a multi-hot message, use priority readMiss > writeMiss > invalidate.
REQ-015 SHALL sample requests only in IDLE; arbitration round-robin via lastGrant, reset so C0 wins the first tie, toggled on each grant.
REQ-016 SHALL in IDLE give an unsolicited write-back (dataWriteBackCx=1) priority over requests: mem[addr] <= data; if Cx is the Exclusive owner, entry -> Uncached, sharers 00; otherwise sharers[x] <= 0; FSM stays IDLE; if both strobe, C0 first, C1 next cycle.
REQ-017 SHALL implement FSM IDLE -> LOOKUP -> (NOTIFY -> REMOTE)? -> REPLY -> IDLE; LOOKUP lasts 1 cycle and latches requester, type, address.
REQ-018 SHALL, readMiss on Uncached/Shared, or any state where requester is sole owner: go to REPLY; entry Shared, sharers |= requester.
REQ-019 SHALL, readMiss on Exclusive owned by other: NOTIFY drives 100 to owner; REMOTE waits; then mem <= write-back data; entry Shared, sharers 11.
REQ-020 SHALL, writeMiss on Exclusive owned by other: NOTIFY drives 010 to owner; REMOTE waits; mem updated; entry Exclusive, sharers = requester.
REQ-021 SHALL, writeMiss or invalidate on Shared with other sharer: NOTIFY drives 001 to other, no REMOTE wait; entry Exclusive, sharers = requester.
REQ-022 SHALL, writeMiss/invalidate with no other holder: go directly to REPLY; entry Exclusive, sharers = requester.
REQ-023 SHALL drive a NOTIFY message for exactly one cycle with addressFromL1 = latched address; all FromL1 outputs 000 and addressFromL1 00 otherwise.
REQ-024 SHALL in REMOTE count cycles; on dataWriteBack from owner exit the next edge; at count == WB_TIMEOUT exit using existing memory data and apply the same directory update.
REQ-025 SHALL in REPLY pulse fetchPresentCx for exactly one cycle with fetchDataCx = mem (post-update), fetchAddressCx = latched address; other reply outputs 0. Invalidate also receives this pulse as acknowledgement.
REQ-026 SHALL meet latency: request seen in IDLE at edge t -> fetchPresent high in cycle t+2 with no remote, t+4+k with remote (k = write-back wait cycles).
REQ-027 SHALL ignore write-back strobes outside IDLE and REMOTE, and non-owner strobes in REMOTE.

Reset
REQ-028 SHALL, while resetN=0 at a clock edge, from any state: FSM -> IDLE, all outputs 0, counter 0, lastGrant -> C0 priority, all dirState Uncached, sharers 00, memory 00; in-flight requests discarded.

Verification
REQ-029 Reset then C0 readMiss addr 0x12 -> fetchPresentC0 at t+2, data 00, dir[0x12] Shared/01.
REQ-030 C1 writeMiss 0x12 after REQ-029 -> C0 sees 001 addr 0x12 one cycle, C1 reply, dir Exclusive/10.
REQ-031 C0 readMiss 0x12 while C1 owns; C1 write-back 0x5A two cycles after 100 -> C0 gets 0x5A, dir Shared/11, mem 0x5A.
REQ-032 Same as REQ-031 with no write-back -> REMOTE exits after 15 cycles, C0 gets old mem data.
REQ-033 C0 and C1 readMiss same cycle twice in a row -> C0 served first, then C1; second tie C1 first.
REQ-034 resetN low during REMOTE -> next cycle busy=0, all outputs 0, no fetchPresent emitted.
